// File: rtl/sfx_arbiter.sv
// sfx_arbiter: fixed-priority sound-effect arbiter sitting between the BGM
// sequencer and the speaker driver. Four SFX ids (0 coin, 1 jump, 2 hit,
// 3 fail) each play a short note list from a built-in table, then a short
// silent gap, before the channel returns to background music.
//
// Build option: define SFX_STEREO_EN to route SFX notes and gap silence to
// freqL only, leaving freqR on bgm_r. Undefined, both channels carry the SFX.
//
// Output value 1 means silence to the speaker driver.

module sfx_arbiter #(
  parameter int TICK_DIV   = 1000000,
  parameter int NOTE_TICKS = 8,
  parameter int GAP_TICKS  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mute,
  input  logic [31:0] bgm_l,
  input  logic [31:0] bgm_r,
  input  logic [3:0]  req,
  output logic [3:0]  ack,
  output logic [31:0] freqL,
  output logic [31:0] freqR,
  output logic        busy,
  output logic [1:0]  active_id
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // One tick counter is shared by notes and the gap, so size it for the larger.
  localparam int CNT_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int DW      = $clog2(TICK_DIV);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);

  // Note table lookup; a zero entry terminates the effect.
  function automatic logic [31:0] sfx_note(input logic [1:0] id, input logic [1:0] note);
    logic [31:0] f;
    case ({id, note})
      4'b00_00: f = 32'd988;
      4'b00_01: f = 32'd1319;
      4'b01_00: f = 32'd523;
      4'b01_01: f = 32'd659;
      4'b01_10: f = 32'd784;
      4'b01_11: f = 32'd1047;
      4'b10_00: f = 32'd196;
      4'b10_01: f = 32'd165;
      4'b10_10: f = 32'd131;
      4'b11_00: f = 32'd392;
      4'b11_01: f = 32'd370;
      4'b11_10: f = 32'd349;
      4'b11_11: f = 32'd330;
      default:  f = 32'd0;
    endcase
    return f;
  endfunction

  // Lowest set request bit wins; caller guarantees r is non-zero.
  function automatic logic [1:0] lowest_id(input logic [3:0] r);
    logic [1:0] w;
    if (r[0]) begin
      w = 2'd0;
    end else if (r[1]) begin
      w = 2'd1;
    end else if (r[2]) begin
      w = 2'd2;
    end else begin
      w = 2'd3;
    end
    return w;
  endfunction

  // Requests that are allowed to preempt the given owner (strictly lower ids).
  function automatic logic [3:0] below_mask(input logic [1:0] id);
    logic [3:0] m;
    case (id)
      2'd0:    m = 4'b0000;
      2'd1:    m = 4'b0001;
      2'd2:    m = 4'b0011;
      2'd3:    m = 4'b0111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    note_q, note_d;
  logic [1:0]    id_q, id_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    ack_q, ack_d;
  logic          busy_q, busy_d;

  logic          tick_s;
  logic          last_note_s;
  logic [1:0]    win_s;
  logic [31:0]   sfx_s;

  assign tick_s      = (div_q == DIV_LAST);
  assign last_note_s = (note_q == 2'd3) || (sfx_note(id_q, note_q + 2'd1) == 32'd0);
  assign win_s       = lowest_id(req);
  assign sfx_s       = sfx_note(id_q, note_q);

  // Next-state logic: grant, note sequencing, preemption and gap timing.
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    id_d    = id_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    ack_d   = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        cnt_d = '0;
        if (req != 4'b0000) begin
          state_d = ST_PLAY;
          note_d  = 2'd0;
          id_d    = win_s;
          ack_d   = onehot(win_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (tick_s) begin
          div_d = '0;
          cnt_d = cnt_q + CW'(1);
        end else begin
          div_d = div_q + DW'(1);
        end
        // A note boundary wins over a same-edge preemption request.
        if (tick_s && (cnt_q == NOTE_LAST)) begin
          div_d = '0;
          cnt_d = '0;
          if (last_note_s) begin
            state_d = ST_GAP;
          end else begin
            note_d = note_q + 2'd1;
          end
        end else if ((req & below_mask(id_q)) != 4'b0000) begin
          state_d = ST_PLAY;
          note_d  = 2'd0;
          id_d    = win_s;
          div_d   = '0;
          cnt_d   = '0;
          ack_d   = onehot(win_s);
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_GAP: begin
        if (tick_s) begin
          div_d = '0;
          cnt_d = cnt_q + CW'(1);
        end else begin
          div_d = div_q + DW'(1);
        end
        if (tick_s && (cnt_q == GAP_LAST)) begin
          state_d = ST_IDLE;
          note_d  = 2'd0;
          id_d    = 2'd0;
          div_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        note_d  = 2'd0;
        id_d    = 2'd0;
        div_d   = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and counter registers; reset drops any effect in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      note_q  <= 2'd0;
      id_q    <= 2'd0;
      div_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      id_q    <= id_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign active_id = id_q;

  // Tone selection: mute beats everything, then SFX/gap, otherwise BGM.
  always_comb begin
    freqL = bgm_l;
    freqR = bgm_r;
    if (mute) begin
      freqL = 32'd1;
      freqR = 32'd1;
    end else if (state_q == ST_PLAY) begin
      freqL = sfx_s;
`ifdef SFX_STEREO_EN
      freqR = bgm_r;
`else
      freqR = sfx_s;
`endif
    end else if (state_q == ST_GAP) begin
      freqL = 32'd1;
`ifdef SFX_STEREO_EN
      freqR = bgm_r;
`else
      freqR = 32'd1;
`endif
    end else begin
      freqL = bgm_l;
      freqR = bgm_r;
    end
  end

endmodule

// File: tb/tb_sfx_arbiter.sv
// Self-checking bench for sfx_arbiter with TICK_DIV=4, NOTE_TICKS=2,
// GAP_TICKS=1 (8-cycle notes, 4-cycle gap). A timeline model computes the
// expected outputs from elapsed cycles since the current grant; directed
// sequences add hand-computed literal checks.

module tb_sfx_arbiter;

  localparam int TICK_DIV   = 4;
  localparam int NOTE_TICKS = 2;
  localparam int GAP_TICKS  = 1;
  localparam int NOTE_CYC   = TICK_DIV * NOTE_TICKS;
  localparam int GAP_CYC    = TICK_DIV * GAP_TICKS;

  logic        clk = 1'b0;
  logic        rst;
  logic        mute;
  logic [31:0] bgm_l;
  logic [31:0] bgm_r;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [31:0] freqL;
  logic [31:0] freqR;
  logic        busy;
  logic [1:0]  active_id;

  int total = 0;
  int bad   = 0;

  sfx_arbiter #(
    .TICK_DIV  (TICK_DIV),
    .NOTE_TICKS(NOTE_TICKS),
    .GAP_TICKS (GAP_TICKS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mute     (mute),
    .bgm_l    (bgm_l),
    .bgm_r    (bgm_r),
    .req      (req),
    .ack      (ack),
    .freqL    (freqL),
    .freqR    (freqR),
    .busy     (busy),
    .active_id(active_id)
  );

  always #5 clk = ~clk;

  // Note table, row = id, 4 entries each; 0 terminates.
  int tbl [16] = '{988, 1319, 0, 0,
                   523, 659, 784, 1047,
                   196, 165, 131, 0,
                   392, 370, 349, 330};

  function automatic int n_notes(input int id);
    for (int i = 0; i < 4; i++) begin
      if (tbl[id*4 + i] == 0) return i;
    end
    return 4;
  endfunction

  function automatic int lowbit(input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[i]) return i;
    end
    return 4;
  endfunction

  // Timeline model state
  bit         m_act   = 1'b0;
  int         m_id    = 0;
  int         m_start = 0;
  int         cyc     = 0;
  logic [3:0] m_ack   = 4'b0000;

  // Model update: grants, preemption away from note boundaries, end of gap.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act   <= 1'b0;
      m_id    <= 0;
      m_start <= 0;
      m_ack   <= 4'b0000;
      cyc     <= 0;
    end else begin
      cyc   <= cyc + 1;
      m_ack <= 4'b0000;
      if (!m_act) begin
        if (req != 4'b0000) begin
          m_act   <= 1'b1;
          m_id    <= lowbit(req);
          m_start <= cyc + 1;
          m_ack   <= 4'(1 << lowbit(req));
        end
      end else if ((cyc - m_start) < NOTE_CYC * n_notes(m_id)) begin
        if ((((cyc - m_start) % NOTE_CYC) != NOTE_CYC - 1) && (lowbit(req) < m_id)) begin
          m_id    <= lowbit(req);
          m_start <= cyc + 1;
          m_ack   <= 4'(1 << lowbit(req));
        end
      end else if ((cyc - m_start) == NOTE_CYC * n_notes(m_id) + GAP_CYC - 1) begin
        m_act <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_sfx(input logic [31:0] bgm);
    int e;
    if (mute) return 32'd1;
    if (!m_act) return bgm;
    e = cyc - m_start;
    if (e < NOTE_CYC * n_notes(m_id)) return 32'(tbl[m_id*4 + e/NOTE_CYC]);
    return 32'd1;
  endfunction

  function automatic logic [31:0] exp_l();
    return exp_sfx(bgm_l);
  endfunction

  function automatic logic [31:0] exp_r();
`ifdef SFX_STEREO_EN
    return mute ? 32'd1 : bgm_r;
`else
    return exp_sfx(bgm_r);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_ack",   32'(ack),       32'(m_ack));
    chk("cmp_busy",  32'(busy),      32'(m_act));
    chk("cmp_id",    32'(active_id), 32'(m_act ? m_id : 0));
    chk("cmp_freqL", freqL,          exp_l());
    chk("cmp_freqR", freqR,          exp_r());
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input string nm, input logic [3:0] mask);
    int k;
    k = 0;
    @(negedge clk);
    while ((ack == 4'b0000) && (k < 100)) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(ack), 32'(mask));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    mute  = 1'b0;
    req   = 4'b0000;
    bgm_l = 32'd440;
    bgm_r = 32'd880;
    tick(3);
    chk("rst_ack",   32'(ack), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_id",    32'(active_id), 32'd0);
    chk("rst_freqL", freqL, 32'd440);
    rst = 1'b1;
    tick(2);

    // id1 full run: four notes then gap
    req = 4'b0010;
    wait_ack("t1_ack", 4'b0010);
    chk("t1_n0", freqL, 32'd523);
    chk("t1_id", 32'(active_id), 32'd1);
    req = 4'b0000;
    tick(8);  chk("t1_n1", freqL, 32'd659);
    tick(8);  chk("t1_n2", freqL, 32'd784);
    tick(8);  chk("t1_n3", freqL, 32'd1047);
    tick(8);  chk("t1_gapL", freqL, 32'd1);
    chk("t1_gapR", freqR, 32'd1);
    tick(3);  chk("t1_busy35", 32'(busy), 32'd1);
    tick(1);  chk("t1_busy36", 32'(busy), 32'd0);
    chk("t1_bgm", freqL, 32'd440);
    tick(2);

    // id0 ends early on the zero entry
    req = 4'b0001;
    wait_ack("t2_ack", 4'b0001);
    chk("t2_n0", freqL, 32'd988);
    req = 4'b0000;
    tick(8);  chk("t2_n1", freqL, 32'd1319);
    tick(8);  chk("t2_gap", freqL, 32'd1);
    tick(4);  chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_bgm", freqL, 32'd440);
    tick(2);

    // id2 preempted by id0 during its second note
    req = 4'b0100;
    wait_ack("t3_ack", 4'b0100);
    chk("t3_n0", freqL, 32'd196);
    req = 4'b0000;
    tick(11); chk("t3_n1", freqL, 32'd165);
    req = 4'b0001;
    tick(1);
    chk("t3_pre_ack", 32'(ack), 32'd1);
    chk("t3_pre_f", freqL, 32'd988);
    chk("t3_pre_id", 32'(active_id), 32'd0);
    req = 4'b0000;
    tick(30);
    chk("t3_idle", 32'(busy), 32'd0);

    // id3 waits for id0 to finish including its gap
    req = 4'b0001;
    wait_ack("t4_ack0", 4'b0001);
    req = 4'b0000;
    tick(2);
    req = 4'b1000;
    tick(18);
    chk("t4_wait_ack", 32'(ack), 32'd0);
    chk("t4_wait_busy", 32'(busy), 32'd0);
    chk("t4_wait_f", freqL, 32'd440);
    tick(1);
    chk("t4_ack3", 32'(ack), 32'h8);
    chk("t4_f3", freqL, 32'd392);
    req = 4'b0000;
    tick(40);

    // mute mid-effect leaves timing intact
    req = 4'b0010;
    wait_ack("t5_ack", 4'b0010);
    req = 4'b0000;
    tick(16); chk("t5_n2", freqL, 32'd784);
    mute = 1'b1;
    #1;
    chk("t5_muteL", freqL, 32'd1);
    chk("t5_muteR", freqR, 32'd1);
    tick(4);
    chk("t5_mute_busy", 32'(busy), 32'd1);
    mute = 1'b0;
    #1;
    chk("t5_resume", freqL, 32'd784);
    tick(4);  chk("t5_n3", freqL, 32'd1047);
    tick(12); chk("t5_end", 32'(busy), 32'd0);
    tick(2);

    // reset mid-play drops the effect immediately
    req = 4'b0010;
    wait_ack("t6_ack", 4'b0010);
    req = 4'b0000;
    tick(5);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rstL", freqL, 32'd440);
    chk("t6_rstR", freqR, 32'd880);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_id", 32'(active_id), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(3);
    chk("t6_after_busy", 32'(busy), 32'd0);
    chk("t6_after_f", freqL, 32'd440);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfx_arbiter.md
SFX_ARBITER -- requirements
Module: sfx_arbiter

Interface
REQ-001 Parameter TICK_DIV, default 1000000, clk cycles per sequencer tick (10 ms at 100 MHz); legal range >=2.
REQ-002 Parameter NOTE_TICKS, default 8, ticks each SFX note is held; legal range >=1.
REQ-003 Parameter GAP_TICKS, default 1, ticks of silence after an SFX ends; legal range >=1.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 mute  input  1  forces both outputs to silence code 1.
REQ-007 bgm_l, bgm_r  input  32 each  current BGM tone in Hz from the active bgm sequencer.
REQ-008 req  input  4  level SFX requests; bit 0 coin, 1 jump, 2 hit, 3 fail; each held until acked.
REQ-009 ack  output  4  one-cycle one-hot grant pulse.
REQ-010 freqL, freqR  output  32 each  tone in Hz to the speaker driver; value 1 means silence.
REQ-011 busy  output  1  high in PLAY or GAP.
REQ-012 active_id  output  2  id of the SFX owning the channel; 0 when idle.

Function
REQ-013 FSM states IDLE, PLAY, GAP; freqL/freqR are combinational from registered state, note index, active_id, mute and bgm inputs.
REQ-014 Note table (Hz), notes 0..3: id0 988,1319,0,0; id1 523,659,784,1047; id2 196,165,131,0; id3 392,370,349,330; entry 0 ends the SFX.
REQ-015 Priority fixed: lower id wins; winner is the lowest set bit of req.
REQ-016 IDLE: freqL=bgm_l, freqR=bgm_r; on an edge with req!=0, next state PLAY, note index 0, active_id=winner, ack[winner]=1 for exactly that following cycle.
REQ-017 Tick divider and note-tick counter clear on every entry to PLAY, on every note advance and on entry to GAP, so each note lasts exactly NOTE_TICKS*TICK_DIV cycles.
REQ-018 PLAY: both outputs carry table[active_id][note]; after NOTE_TICKS ticks, note increments; if note was 3 or next entry is 0, enter GAP.
REQ-019 Preemption: in PLAY, if req has a bit with index below active_id, restart PLAY at note 0 with the new id and pulse its ack; equal or higher-index requests wait, unacked.
REQ-020 GAP: both outputs 1 for GAP_TICKS ticks, then IDLE; a request pending at GAP exit is granted on the next edge per REQ-016 (no preemption during GAP).
REQ-021 Requests arriving on the same edge as a note advance or GAP exit: the state transition completes first; the request is evaluated on the following edge.
REQ-022 mute overrides outputs only: freqL=freqR=1, FSM, counters and ack run unchanged.
REQ-023 ack never has more than one bit set; ack never asserts for a bit with req low.

Reset
REQ-024 rst low asynchronously forces IDLE, note=0, active_id=0, ack=0, busy=0, all counters 0.
REQ-025 During and after reset, freqL/freqR = mute ? 1 : bgm_l/bgm_r; an SFX interrupted by reset is dropped, not resumed.

Configuration
REQ-026 Macro SFX_STEREO_EN: defined -> SFX notes and GAP silence drive freqL only, freqR always passes bgm_r (or 1 when muted); undefined -> SFX and GAP drive both channels per REQ-018/REQ-020.

Verification
(Bench parameters TICK_DIV=4, NOTE_TICKS=2, GAP_TICKS=1: note = 8 cycles, gap = 4 cycles; SFX_STEREO_EN undefined unless stated.)
REQ-027 req=0010 held until ack, bgm_l=440 -> ack=0010 one cycle; freqL 523,659,784,1047 for 8 cycles each; then 1 for 4 cycles; then 440; busy high 36 cycles.
REQ-028 req=0001 -> 988 then 1319 for 8 cycles each, GAP 4 cycles, IDLE (early end on zero entry).
REQ-029 id2 playing note 1, assert req=0001 -> same-edge-plus-one ack=0001, freqL=988, active_id=0; id2 never acked again.
REQ-030 id0 playing, assert req=1000 -> no ack until id0's GAP ends; next edge ack=1000, freqL=392.
REQ-031 mute=1 during id1 note 2 -> freqL=freqR=1, ack/busy timing identical to REQ-027; release mute mid-note -> 784 resumes with remaining count intact.
REQ-032 rst low mid-PLAY -> outputs immediately bgm values, busy=0, active_id=0; with SFX_STEREO_EN defined, REQ-027 shows freqR=bgm_r throughout.
